aes_bist_ctrl: RTL and testbench

// - Sequencer driving the BIST side of the AES-128 8-bit-datapath BIST wrapper.
// - Owns the wrapper's is_bist, en_lsfr_misr and rst lines. Waits for AES DONE.
// - Freezes the MISR, captures the 8-bit signature and compares it to a golden value.
// - Reports busy/done/pass to the test host. Sits between host/JTAG glue and the wrapper.

---
 rtl/aes_bist_ctrl.sv | 137 +++++++++++++
 tb/tb_aes_bist_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/aes_bist_ctrl.sv
// BIST sequencer for the AES-128 8-bit-datapath wrapper: reset, run, drain, signature check.
// Optional RUN watchdog is built only when AES_BIST_TIMEOUT_EN is defined.
module aes_bist_ctrl #(
  parameter int          RST_CYCLES   = 4,
  parameter int          DRAIN_CYCLES = 16,
  parameter int          TIMEOUT      = 4096,
  parameter logic [7:0]  GOLDEN_SIG   = 8'hC0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bist_start,
  input  logic       bist_abort,
  input  logic       dut_done,
  input  logic [7:0] dut_sig,
  output logic       dut_rst,
  output logic       is_bist,
  output logic       en_lsfr_misr,
  output logic       bist_busy,
  output logic       bist_done,
  output logic       bist_pass,
  output logic       bist_timeout,
  output logic [7:0] bist_sig
);

  localparam int CNT_RD  = (RST_CYCLES > DRAIN_CYCLES) ? RST_CYCLES : DRAIN_CYCLES;
  localparam int CNT_MAX = (CNT_RD > TIMEOUT) ? CNT_RD : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LOAD   = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_CYCLES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_RESET, S_RUN, S_DRAIN, S_CHECK, S_RESULT
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

`ifdef AES_BIST_TIMEOUT_EN
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] timer;
`endif

  // NOTE: every register here uses <= so all updates see the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || bist_abort) begin
      state        <= S_IDLE;
      cnt          <= '0;
      dut_rst      <= 1'b0;
      is_bist      <= 1'b0;
      en_lsfr_misr <= 1'b0;
      bist_busy    <= 1'b0;
      bist_done    <= 1'b0;
      bist_pass    <= 1'b0;
      bist_timeout <= 1'b0;
      bist_sig     <= '0;
`ifdef AES_BIST_TIMEOUT_EN
      timer        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE, S_RESULT: begin
          if (bist_start) begin
            state        <= S_RESET;
            cnt          <= RST_LOAD;
            dut_rst      <= 1'b1;
            is_bist      <= 1'b1;
            en_lsfr_misr <= 1'b0;
            bist_busy    <= 1'b1;
            bist_done    <= 1'b0;
            bist_pass    <= 1'b0;
            bist_timeout <= 1'b0;
            bist_sig     <= '0;
          end
        end
        S_RESET: begin
          // A DONE left high by a previous run is ignored while the wrapper is held in reset.
          if (cnt == '0) begin
            state        <= S_RUN;
            dut_rst      <= 1'b0;
            en_lsfr_misr <= 1'b1;
`ifdef AES_BIST_TIMEOUT_EN
            timer        <= '0;
`endif
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_RUN: begin
          if (dut_done) begin
            if (DRAIN_CYCLES == 0) begin
              state        <= S_CHECK;
              en_lsfr_misr <= 1'b0;
            end else begin
              state <= S_DRAIN;
              cnt   <= DRAIN_LOAD;
            end
          end
`ifdef AES_BIST_TIMEOUT_EN
          else if (timer == TO_LAST) begin
            state        <= S_RESULT;
            is_bist      <= 1'b0;
            en_lsfr_misr <= 1'b0;
            bist_busy    <= 1'b0;
            bist_done    <= 1'b1;
            bist_pass    <= 1'b0;
            bist_timeout <= 1'b1;
          end else begin
            timer <= timer + CNT_ONE;
          end
`endif
        end
        S_DRAIN: begin
          if (cnt == CNT_ONE) begin
            state        <= S_CHECK;
            cnt          <= '0;
            en_lsfr_misr <= 1'b0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_CHECK: begin
          // MISR is frozen here, so d_out is a stable signature for exactly this cycle.
          state     <= S_RESULT;
          is_bist   <= 1'b0;
          bist_busy <= 1'b0;
          bist_done <= 1'b1;
          bist_sig  <= dut_sig;
          bist_pass <= (dut_sig == GOLDEN_SIG);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_bist_ctrl.sv
// Self-checking bench for aes_bist_ctrl: phase-timed reference of control outputs and results.
module tb_aes_bist_ctrl;

  localparam int         R    = 4;
  localparam int         D    = 16;
  localparam int         TO   = 64;
  localparam logic [7:0] GOLD = 8'hC0;

  logic       clk = 1'b0;
  logic       rst, bist_start, bist_abort, dut_done;
  logic [7:0] dut_sig;
  logic       dut_rst, is_bist, en_lsfr_misr, bist_busy, bist_done, bist_pass, bist_timeout;
  logic [7:0] bist_sig;

  int checks   = 0;
  int failures = 0;

  aes_bist_ctrl #(
    .RST_CYCLES(R), .DRAIN_CYCLES(D), .TIMEOUT(TO), .GOLDEN_SIG(GOLD)
  ) dut (
    .clk(clk), .rst(rst), .bist_start(bist_start), .bist_abort(bist_abort),
    .dut_done(dut_done), .dut_sig(dut_sig), .dut_rst(dut_rst), .is_bist(is_bist),
    .en_lsfr_misr(en_lsfr_misr), .bist_busy(bist_busy), .bist_done(bist_done),
    .bist_pass(bist_pass), .bist_timeout(bist_timeout), .bist_sig(bist_sig)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] all_out();
    return {dut_rst, is_bist, en_lsfr_misr, bist_busy, bist_done,
            bist_pass, bist_timeout, bist_sig};
  endfunction

  // Expected {dut_rst,is_bist,en,busy,done} k cycles after the start was sampled.
  function automatic logic [4:0] exp_ctrl(input int k, input int run_end, input bit tmo);
    if (k <= R)                 return 5'b11010;
    if (k <= run_end)           return 5'b01110;
    if (tmo)                    return 5'b00001;
    if (k <= run_end + D)       return 5'b01110;
    if (k == run_end + D + 1)   return 5'b01010;
    return 5'b00001;
  endfunction

  // One test from IDLE/RESULT; stop_k>0 injects abort(1), abort+start(2) or rst(3) in cycle stop_k.
  task automatic run_seq(input string tag, input int n_run, input logic [7:0] sig,
                         input bit stuck, input int busy_k, input int stop_k,
                         input int stop_kind, input bit tmo);
    int          run_end, check_k, last;
    bit          in_run, exp_pass;
    logic [4:0]  ev, gv;
    logic [7:0]  exp_sig;
    logic [14:0] held;
    run_end = tmo ? R + TO : R + n_run;
    check_k = run_end + D + 1;
    last    = tmo ? run_end + 1 : check_k + 1;

    bist_start = 1'b1;
    bist_abort = 1'b0;
    dut_done   = stuck ? 1'b1 : 1'($urandom);
    dut_sig    = 8'($urandom);
    step();
    bist_start = 1'b0;
    checks++;
    if ({bist_pass, bist_timeout, bist_sig} !== 10'h0) begin
      failures++;
      $display("FAIL %s start_clear: pass/timeout/sig=%b got, 0 required", tag,
               {bist_pass, bist_timeout, bist_sig});
    end

    for (int k = 1; k <= last; k++) begin
      if (k > 1) step();
      ev = exp_ctrl(k, run_end, tmo);
      gv = {dut_rst, is_bist, en_lsfr_misr, bist_busy, bist_done};
      checks++;
      if (gv !== ev) begin
        failures++;
        $display("FAIL %s ctrl k=%0d: got %b, required %b", tag, k, gv, ev);
      end
      if (k == stop_k) begin
        dut_done = 1'($urandom);
        if (stop_kind == 3) rst = 1'b1;
        else begin
          bist_abort = 1'b1;
          bist_start = (stop_kind == 2);
        end
        step();
        rst = 1'b0; bist_abort = 1'b0; bist_start = 1'b0;
        checks++;
        if (all_out() !== 15'h0) begin
          failures++;
          $display("FAIL %s stop k=%0d: outputs %h, required 0000", tag, k, all_out());
        end
        dut_done = stuck ? 1'b1 : 1'b0;
        step();
        checks++;
        if (all_out() !== 15'h0) begin
          failures++;
          $display("FAIL %s stay_idle: outputs %h, required 0000", tag, all_out());
        end
        return;
      end
      in_run = (k > R) && (k <= run_end);
      if (stuck)       dut_done = 1'b1;
      else if (in_run) dut_done = !tmo && (k == run_end);
      else             dut_done = 1'($urandom);
      dut_sig    = (k == check_k) ? sig : sig ^ 8'($urandom_range(1, 255));
      bist_start = (k == busy_k);
    end
    bist_start = 1'b0;

    exp_pass = !tmo && (sig == GOLD);
    exp_sig  = tmo ? 8'h00 : sig;
    checks++;
    if ({bist_pass, bist_timeout, bist_sig} !== {exp_pass, tmo, exp_sig}) begin
      failures++;
      $display("FAIL %s result: pass=%b timeout=%b sig=%h, required pass=%b timeout=%b sig=%h",
               tag, bist_pass, bist_timeout, bist_sig, exp_pass, tmo, exp_sig);
    end
    held = all_out();
    for (int h = 0; h < 3; h++) begin
      dut_done = 1'($urandom);
      dut_sig  = 8'($urandom);
      step();
      checks++;
      if (all_out() !== held) begin
        failures++;
        $display("FAIL %s hold h=%0d: outputs %h, required %h", tag, h, all_out(), held);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; bist_start = 1'b1; bist_abort = 1'b0; dut_done = 1'b1; dut_sig = 8'($urandom);
    step();
    step();
    checks++;
    if (all_out() !== 15'h0) begin
      failures++;
      $display("FAIL reset: outputs %h, required 0000", all_out());
    end
    rst = 1'b0; bist_start = 1'b0; dut_done = 1'b0;
    step();
    checks++;
    if (all_out() !== 15'h0) begin
      failures++;
      $display("FAIL idle: outputs %h, required 0000", all_out());
    end
  endtask

  task automatic test_golden();
    for (int i = 0; i < 4; i++)
      run_seq("golden", $urandom_range(1, 30), GOLD, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_fault();
    logic [7:0] s;
    for (int i = 0; i < 3; i++) begin
      s = GOLD ^ (8'h01 << $urandom_range(0, 7));
      run_seq("fault", $urandom_range(1, 30), s, 1'b0, 0, 0, 0, 1'b0);
    end
  endtask

  task automatic test_start_while_busy();
    run_seq("busy_start", $urandom_range(6, 20), GOLD ^ 8'h10, 1'b0, R + 3, 0, 0, 1'b0);
    run_seq("restart", $urandom_range(1, 10), GOLD, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_abort();
    run_seq("abort_run", 20, GOLD, 1'b0, 0, R + 5, 1, 1'b0);
    run_seq("after_abort_run", 7, GOLD, 1'b0, 0, 0, 0, 1'b0);
    run_seq("abort_drain", 9, GOLD, 1'b0, 0, R + 9 + 4, 2, 1'b0);
    run_seq("after_abort_drain", 3, GOLD, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic test_rst_mid_drain();
    run_seq("rst_drain", 10, GOLD, 1'b0, 0, R + 10 + 8, 3, 1'b0);
    run_seq("stuck_done", 1, GOLD, 1'b1, 0, 0, 0, 1'b0);
    dut_done = 1'b0;
  endtask

  task automatic test_watchdog();
`ifdef AES_BIST_TIMEOUT_EN
    run_seq("timeout", 0, GOLD, 1'b0, 0, 0, 0, 1'b1);
`else
    run_seq("hang_abort", 300, GOLD, 1'b0, 0, R + 200, 1, 1'b0);
`endif
    run_seq("done_at_expiry", TO, GOLD, 1'b0, 0, 0, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; bist_start = 1'b0; bist_abort = 1'b0; dut_done = 1'b0; dut_sig = 8'h00;
    test_reset();
    test_golden();
    test_fault();
    test_start_while_busy();
    test_abort();
    test_rst_mid_drain();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
